psum_accumulator: RTL and testbench

PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

---
 rtl/acc_pkg.sv | 35 +++
 rtl/psum_lane.sv | 87 ++++++++
 rtl/psum_accumulator.sv | 93 +++++++++
 tb/tb_psum_accumulator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared helpers for the partial-sum accumulator: lane/row slice offsets and signed saturation.
package acc_pkg;

    localparam int unsigned MAX_W = 128;

    function automatic int unsigned row_lsb(input int unsigned r, input int unsigned m,
                                            input int unsigned dw, input int unsigned dp);
        return dw * (r * dp + m);
    endfunction

    function automatic int unsigned lane_lsb(input int unsigned m, input int unsigned dw);
        return dw * m;
    endfunction

    // Treats the low aw bits of v as signed and clamps them to the dw-bit signed range.
    function automatic logic signed [MAX_W-1:0] sat_conv(input logic signed [MAX_W-1:0] v,
                                                         input int unsigned aw,
                                                         input int unsigned dw);
        logic signed [MAX_W-1:0] x;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        x  = v <<< (MAX_W - aw);
        x  = x >>> (MAX_W - aw);
        hi = MAX_W'(1) << (dw - 1);
        hi = hi - MAX_W'(1);
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/psum_lane.sv
// One lane: REG_NUM-stage row reduction, group accumulator and output ReLU/saturation register.
module psum_lane
    import acc_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned REG_NUM = 3,
    parameter int unsigned AW      = 40,
    parameter int unsigned SAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  sum_v_i,
    input  logic                  first_i,
    input  logic                  out_load_i,
    input  logic                  out_relu_i,
    input  logic [REG_NUM*DW-1:0] rows_i,
    output logic [DW-1:0]         data_o
);

    logic [REG_NUM-1:0][DW-1:0] row_dly;
    logic signed [AW-1:0]       psum_q [REG_NUM];
    logic signed [AW-1:0]       acc_q;
    logic signed [AW-1:0]       acc_d;
    logic signed [AW-1:0]       relu_val;
    logic [DW-1:0]              data_q;
    logic [DW-1:0]              data_d;

    assign row_dly[0] = rows_i[DW-1:0];

    // Row r is delayed r cycles so it meets its partial sum at stage r.
    for (genvar r = 1; r < REG_NUM; r++) begin : g_dly
        logic [DW-1:0] dly_q [r];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int j = 0; j < r; j++) dly_q[j] <= '0;
            end else if (en_i) begin
                dly_q[0] <= rows_i[r*DW +: DW];
                for (int j = 1; j < r; j++) dly_q[j] <= dly_q[j-1];
            end
        end
        assign row_dly[r] = dly_q[r-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_NUM; k++) psum_q[k] <= '0;
        end else if (en_i) begin
            psum_q[0] <= AW'($signed(row_dly[0]));
            for (int k = 1; k < REG_NUM; k++) begin
                psum_q[k] <= psum_q[k-1] + AW'($signed(row_dly[k]));
            end
        end
    end

    always_comb begin
        acc_d    = acc_q;
        relu_val = acc_q;
        data_d   = data_q;
        if (sum_v_i) begin
            acc_d = first_i ? psum_q[REG_NUM-1] : acc_q + psum_q[REG_NUM-1];
        end
        if (out_relu_i && acc_q[AW-1]) begin
            relu_val = '0;
        end
        if (out_load_i) begin
            if (SAT != 0) begin
                data_d = DW'(sat_conv(MAX_W'(relu_val), AW, DW));
            end else begin
                data_d = DW'(relu_val);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q  <= '0;
            data_q <= '0;
        end else if (en_i) begin
            acc_q  <= acc_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/psum_accumulator.sv
// Multi-lane partial-sum accumulator: shared handshake/sideband pipeline driving DP lanes.
module psum_accumulator
    import acc_pkg::*;
#(
    parameter int unsigned DW      = 32,
    parameter int unsigned DP      = 56,
    parameter int unsigned REG_NUM = 3,
    parameter int unsigned AW      = 40,
    parameter int unsigned SAT     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     last_i,
    input  logic                     relu_i,
    input  logic [REG_NUM*DW*DP-1:0] data_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [DW*DP-1:0]         data_o
);

    logic               en;
    logic [REG_NUM-1:0] sv_q;
    logic [REG_NUM-1:0] sl_q;
    logic [REG_NUM-1:0] sr_q;
    logic               av_q;
    logic               al_q;
    logic               ar_q;
    logic               first_q;
    logic               first_d;
    logic               valid_q;
    logic               valid_d;

    // Whole pipeline advances only when the output register is free or being drained.
    assign en      = !valid_q || ready_i;
    assign ready_o = en;
    assign valid_o = valid_q;

    always_comb begin
        first_d = first_q;
        valid_d = av_q && al_q;
        if (sv_q[REG_NUM-1]) begin
            first_d = sl_q[REG_NUM-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sv_q    <= '0;
            sl_q    <= '0;
            sr_q    <= '0;
            av_q    <= 1'b0;
            al_q    <= 1'b0;
            ar_q    <= 1'b0;
            first_q <= 1'b1;
            valid_q <= 1'b0;
        end else if (en) begin
            sv_q    <= {sv_q[REG_NUM-2:0], valid_i};
            sl_q    <= {sl_q[REG_NUM-2:0], last_i};
            sr_q    <= {sr_q[REG_NUM-2:0], relu_i};
            av_q    <= sv_q[REG_NUM-1];
            al_q    <= sl_q[REG_NUM-1];
            ar_q    <= sr_q[REG_NUM-1];
            first_q <= first_d;
            valid_q <= valid_d;
        end
    end

    for (genvar m = 0; m < DP; m++) begin : g_lane
        logic [REG_NUM*DW-1:0] rows;
        for (genvar r = 0; r < REG_NUM; r++) begin : g_row
            assign rows[r*DW +: DW] = data_i[row_lsb(r, m, DW, DP) +: DW];
        end
        psum_lane #(
            .DW      (DW),
            .REG_NUM (REG_NUM),
            .AW      (AW),
            .SAT     (SAT)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (en),
            .sum_v_i    (sv_q[REG_NUM-1]),
            .first_i    (first_q),
            .out_load_i (av_q && al_q),
            .out_relu_i (ar_q),
            .rows_i     (rows),
            .data_o     (data_o[lane_lsb(m, DW) +: DW])
        );
    end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: saturating and wrapping instances against a group-sum reference model.
module tb_psum_accumulator;

    localparam int unsigned DW   = 8;
    localparam int unsigned DP   = 2;
    localparam int unsigned RN   = 3;
    localparam int unsigned AW   = 12;
    localparam int unsigned DWID = RN * DW * DP;
    localparam int unsigned OWID = DW * DP;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            valid_i;
    logic            last_i;
    logic            relu_i;
    logic            ready_i;
    logic [DWID-1:0] data_i;
    logic            ready_s, ready_w, valid_s, valid_w;
    logic [OWID-1:0] data_s, data_w;

    int errors = 0;
    int checks = 0;

    longint          grp [DP];
    logic [OWID-1:0] q_s [$];
    logic [OWID-1:0] q_w [$];
    int              n_exp = 0;
    int              n_got = 0;
    bit              stall_prev = 1'b0;
    logic [OWID-1:0] held_s, held_w;
    bit              rand_ready = 1'b0;

    always #5 clk = ~clk;

    psum_accumulator #(.DW(DW), .DP(DP), .REG_NUM(RN), .AW(AW), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_s), .last_i(last_i),
        .relu_i(relu_i), .data_i(data_i), .valid_o(valid_s), .ready_i(ready_i), .data_o(data_s)
    );

    psum_accumulator #(.DW(DW), .DP(DP), .REG_NUM(RN), .AW(AW), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_w), .last_i(last_i),
        .relu_i(relu_i), .data_i(data_i), .valid_o(valid_w), .ready_i(ready_i), .data_o(data_w)
    );

    task automatic check_eq(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint beat_sum(input logic [DWID-1:0] d, input int m);
        logic [DW-1:0] w;
        longint s = 0;
        for (int r = 0; r < int'(RN); r++) begin
            w = d[DW*(r*DP+m) +: DW];
            s += longint'($signed(w));
        end
        return s;
    endfunction

    // Group result: wrap to AW signed, optional ReLU, then saturate or keep low DW bits.
    function automatic logic [DW-1:0] conv(input longint g, input bit relu, input bit sat);
        longint v;
        longint span = longint'(1) << AW;
        v = g & (span - 1);
        if (v >= span / 2) v -= span;
        if (relu && v < 0) v = 0;
        if (sat) begin
            if (v > 127) v = 127;
            if (v < -128) v = -128;
        end
        return DW'(v);
    endfunction

    function automatic logic [DWID-1:0] mk(input int a0, input int a1, input int a2,
                                           input int b0, input int b1, input int b2);
        logic [DWID-1:0] d;
        int a [RN];
        int b [RN];
        a = '{a0, a1, a2};
        b = '{b0, b1, b2};
        d = '0;
        for (int r = 0; r < int'(RN); r++) begin
            d[DW*(r*DP)   +: DW] = DW'(a[r]);
            d[DW*(r*DP+1) +: DW] = DW'(b[r]);
        end
        return d;
    endfunction

    always @(negedge clk) begin
        if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
    end

    // Reference model and handshake monitor, sampled after inputs settle each low phase.
    always @(negedge clk) begin
        logic [OWID-1:0] es, ew;
        #2;
        if (!rst_n) begin
            for (int m = 0; m < int'(DP); m++) grp[m] = 0;
            n_exp -= q_s.size();
            q_s.delete();
            q_w.delete();
            stall_prev = 1'b0;
        end else begin
            check_eq("ready_o", longint'(ready_s), longint'(!valid_s || ready_i));
            check_eq("valid_pair", longint'(valid_w), longint'(valid_s));
            if (stall_prev) begin
                check_eq("hold_valid", longint'(valid_s), 1);
                check_eq("hold_data_sat", longint'(data_s), longint'(held_s));
                check_eq("hold_data_wrap", longint'(data_w), longint'(held_w));
            end
            if (valid_s && ready_i) begin
                check_eq("result_pending", longint'(q_s.size() > 0), 1);
                if (q_s.size() > 0) begin
                    es = q_s.pop_front();
                    ew = q_w.pop_front();
                    check_eq("data_sat", longint'(data_s), longint'(es));
                    check_eq("data_wrap", longint'(data_w), longint'(ew));
                    n_got++;
                end
            end
            stall_prev = valid_s && !ready_i;
            held_s     = data_s;
            held_w     = data_w;
            if (valid_i && ready_s) begin
                for (int m = 0; m < int'(DP); m++) grp[m] += beat_sum(data_i, m);
                if (last_i) begin
                    for (int m = 0; m < int'(DP); m++) begin
                        es[DW*m +: DW] = conv(grp[m], relu_i, 1'b1);
                        ew[DW*m +: DW] = conv(grp[m], relu_i, 1'b0);
                        grp[m] = 0;
                    end
                    q_s.push_back(es);
                    q_w.push_back(ew);
                    n_exp++;
                end
            end
        end
    end

    task automatic send(input bit last, input bit relu, input logic [DWID-1:0] d);
        int t = 0;
        @(negedge clk);
        valid_i = 1'b1;
        last_i  = last;
        relu_i  = relu;
        data_i  = d;
        #2;
        while (!ready_s && t < 60) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (t >= 60) check_eq("send_timeout", t, 0);
    endtask

    task automatic wait_result(input string tag, input int exp_s, input int exp_w, input int exp_lat);
        int lat;
        @(negedge clk);
        valid_i = 1'b0;
        last_i  = 1'b0;
        #2;
        lat = 1;
        while (!valid_s && lat < 40) begin
            @(negedge clk);
            #2;
            lat++;
        end
        check_eq({tag, "_valid"}, longint'(valid_s), 1);
        if (exp_lat >= 0) check_eq({tag, "_latency"}, lat - 1, exp_lat);
        check_eq({tag, "_sat"}, longint'($signed(data_s[DW-1:0])), exp_s);
        check_eq({tag, "_wrap"}, longint'($signed(data_w[DW-1:0])), exp_w);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while (q_s.size() != 0 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        check_eq({tag, "_drain"}, q_s.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        last_i  = 1'b0;
        relu_i  = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        repeat (3) @(negedge clk);
        #2;
        check_eq("rst_ready", longint'(ready_s), 1);
        check_eq("rst_valid", longint'(valid_s), 0);
        check_eq("rst_data", longint'(data_s), 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(1'b1, 1'b0, mk(1, 2, 3, 4, -1, 7));
        wait_result("one_beat", 6, 6, int'(RN) + 1);

        send(1'b0, 1'b0, mk(3, 3, 4, 1, 1, 1));
        send(1'b0, 1'b0, mk(-1, -1, -2, -9, 0, 2));
        send(1'b1, 1'b0, mk(2, 2, 3, 5, 5, 5));
        wait_result("three_beat", 13, 13, -1);
        send(1'b1, 1'b0, mk(1, 1, 1, 0, 0, 0));
        wait_result("next_group", 3, 3, -1);

        send(1'b1, 1'b0, mk(100, 100, 100, -100, -100, -100));
        wait_result("saturate", 127, 44, -1);

        send(1'b1, 1'b1, mk(-2, -2, -1, 3, 3, 3));
        wait_result("relu_on", 0, 0, -1);
        send(1'b1, 1'b0, mk(-2, -2, -1, 3, 3, 3));
        wait_result("relu_off", -5, -5, -1);
        drain("directed");

        ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) send(1'b1, 1'b0, mk(k, 0, 0, 0, k, 0));
        @(negedge clk);
        data_i = mk(5, 0, 0, 0, 5, 0);
        @(negedge clk);
        data_i = mk(6, 0, 0, 0, 6, 0);
        for (int i = 0; i < 5; i++) begin
            #2;
            check_eq("bp_valid", longint'(valid_s), 1);
            check_eq("bp_ready", longint'(ready_s), 0);
            check_eq("bp_data", longint'($signed(data_s[DW-1:0])), 1);
            @(negedge clk);
        end
        ready_i = 1'b1;
        begin
            int t = 0;
            #2;
            while (!ready_s && t < 20) begin
                @(negedge clk);
                #2;
                t++;
            end
        end
        @(negedge clk);
        valid_i = 1'b0;
        drain("backpressure");

        send(1'b0, 1'b0, mk(5, 5, 5, 1, 1, 1));
        send(1'b0, 1'b0, mk(7, 7, 7, 2, 2, 2));
        @(negedge clk);
        valid_i = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check_eq("midrst_valid", longint'(valid_s), 0);
        check_eq("midrst_data", longint'(data_s), 0);
        send(1'b1, 1'b0, mk(2, 3, 4, 1, 0, 0));
        wait_result("after_reset", 9, 9, -1);
        drain("reset");

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                valid_i = 1'b0;
            end else begin
                send($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                     DWID'({$urandom(), $urandom()}));
            end
        end
        send(1'b1, 1'b0, DWID'({$urandom(), $urandom()}));
        @(negedge clk);
        rand_ready = 1'b0;
        valid_i    = 1'b0;
        ready_i    = 1'b1;
        drain("random");
        check_eq("result_count", n_got, n_exp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
